// File: rtl/output_port_pkg.sv
// rtl/output_port_pkg.sv - shared output-stage definitions
//
// Holds the output-select encodings shared with the sequence control matrix
// and the default geometry of the output FIFO.
package output_port_pkg;

  // Output-select encodings driven by the matrix out_sel_o.
  localparam logic OUT_SEL_REG = 1'b0;  // register/ALU result word (src0_i)
  localparam logic OUT_SEL_IMM = 1'b1;  // zero-extended IR immediate (src1_i)

  // Default output FIFO geometry.
  localparam int OUT_DATA_WIDTH = 16;
  localparam int OUT_DEPTH      = 4;
  localparam int OUT_ADDR_BITS  = 2;

endpackage

// File: rtl/output_port_if.sv
// rtl/output_port_if.sv - load-side and consumer-side bus of the output stage
//
// Signals:
//   ld_ni    active-low load strobe from the matrix (out_ld_no)
//   sel_i    source select from the matrix (out_sel_o)
//   src0_i   register/ALU result word
//   src1_i   zero-extended IR immediate
//   data_o   head-of-FIFO word, 0 when empty
//   valid_o  head word is valid
//   ready_i  consumer accepts the head word
// Modports:
//   master   environment side: drives loads and ready, observes the head word
//   slave    output_port side
interface output_port_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  ld_ni;
  logic                  sel_i;
  logic [DATA_WIDTH-1:0] src0_i;
  logic [DATA_WIDTH-1:0] src1_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output ld_ni, sel_i, src0_i, src1_i, ready_i,
    input  data_o, valid_o
  );

  modport slave (
    input  ld_ni, sel_i, src0_i, src1_i, ready_i,
    output data_o, valid_o
  );

endinterface

// File: rtl/output_fifo_mem.sv
// rtl/output_fifo_mem.sv - output FIFO storage array
//
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are never cleared.
// Ports:
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module output_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_BITS-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/output_port.sv
// rtl/output_port.sv - output stage FIFO between the sequence matrix and a consumer
//
// Captures the selected datapath word on each active-low load strobe into a
// small first-word-fall-through FIFO and drains it over valid/ready.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   bus         load strobe/select/sources in, head word/valid out, ready in
//   full_o      count == DEPTH; stall request to the matrix
//   empty_o     count == 0
//   count_o     number of occupied entries
//   overflow_o  sticky: a load was dropped while full
//   last_o      last word accepted into the FIFO
module output_port
  import output_port_pkg::*;
#(
  parameter int DATA_WIDTH = OUT_DATA_WIDTH,
  parameter int DEPTH      = OUT_DEPTH,
  parameter int ADDR_BITS  = OUT_ADDR_BITS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output_port_if.slave          bus,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_BITS:0]    count_o,
  output logic                  overflow_o,
  output logic [DATA_WIDTH-1:0] last_o
);

  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS:0]    count;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] last_word;
  logic [DATA_WIDTH-1:0] push_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Flags decode from the registered count only; pointer equality is never
  // used because the pointers alias when full and when empty.
  assign full  = (count == (ADDR_BITS+1)'(DEPTH));
  assign empty = (count == '0);

  assign pop  = !empty && bus.ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = !bus.ld_ni && (!full || pop);
  assign drop = !bus.ld_ni && full && !pop;

  assign push_word = (bus.sel_i == OUT_SEL_IMM) ? bus.src1_i : bus.src0_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_word <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + ADDR_BITS'(1);
        last_word <= push_word;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
      if (push && !pop) begin
        count <= count + (ADDR_BITS+1)'(1);
      end else if (pop && !push) begin
        count <= count - (ADDR_BITS+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Writes are suppressed during reset so a reset edge never leaves a stale
  // word behind a pointer that has just been cleared.
  output_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push && !reset_i),
    .waddr_i (wr_ptr),
    .wdata_i (push_word),
    .raddr_i (rd_ptr),
    .rdata_o (rd_word)
  );

  assign bus.data_o  = empty ? '0 : rd_word;
  assign bus.valid_o = !empty;
  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count;
  assign overflow_o  = overflow;
  assign last_o      = last_word;

endmodule

// File: tb/tb_output_port.sv
// tb/tb_output_port.sv - directed self-checking bench for output_port
module tb_output_port;

  logic        clk_i;
  logic        reset_i;
  logic        full_o;
  logic        empty_o;
  logic [2:0]  count_o;
  logic        overflow_o;
  logic [15:0] last_o;

  int compared;
  int mismatched;

  output_port_if #(.DATA_WIDTH(16)) bus ();

  output_port #(
    .DATA_WIDTH (16),
    .DEPTH      (4),
    .ADDR_BITS  (2)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .bus        (bus),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .last_o     (last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_i     = 1'b1;
    bus.ld_ni   = 1'b1;
    bus.sel_i   = 1'b0;
    bus.src0_i  = 16'h0000;
    bus.src1_i  = 16'h0000;
    bus.ready_i = 1'b0;

    // 1. reset for two cycles with ld_ni high
    tick();
    tick();
    reset_i = 1'b0;
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'h0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_last", 32'(last_o), 32'h0);

    // 2. single push of the immediate, held with ready low
    bus.ld_ni  = 1'b0;
    bus.sel_i  = 1'b1;
    bus.src1_i = 16'h00A5;
    bus.src0_i = 16'h0BAD;
    tick();
    bus.ld_ni = 1'b1;
    check("t2_valid", 32'(bus.valid_o), 32'd1);
    check("t2_data", 32'(bus.data_o), 32'h00A5);
    check("t2_last", 32'(last_o), 32'h00A5);
    check("t2_count", 32'(count_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_data", 32'(bus.data_o), 32'h00A5);
      check("t2_hold_valid", 32'(bus.valid_o), 32'd1);
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check("t2_drain_empty", 32'(empty_o), 32'd1);

    // 3. fill with register words, then overflow
    bus.sel_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.ld_ni  = 1'b0;
      bus.src0_i = 16'(i);
      tick();
    end
    check("t3_full_before", 32'(full_o), 32'd1);
    check("t3_count_before", 32'(count_o), 32'd4);
    check("t3_ovf_before", 32'(overflow_o), 32'd0);
    bus.src0_i = 16'h0005;
    tick();
    bus.ld_ni = 1'b1;
    check("t3_full", 32'(full_o), 32'd1);
    check("t3_count", 32'(count_o), 32'd4);
    check("t3_overflow", 32'(overflow_o), 32'd1);
    check("t3_last", 32'(last_o), 32'h0004);
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain_data", 32'(bus.data_o), 32'(i));
      tick();
    end
    bus.ready_i = 1'b0;
    check("t3_empty", 32'(empty_o), 32'd1);
    check("t3_ovf_sticky", 32'(overflow_o), 32'd1);
    check("t3_empty_data", 32'(bus.data_o), 32'h0);

    // 4. full FIFO with simultaneous push and pop
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t4_ovf_cleared", 32'(overflow_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      bus.ld_ni  = 1'b0;
      bus.src0_i = 16'h0010 + 16'(i);
      tick();
    end
    check("t4_full", 32'(full_o), 32'd1);
    bus.src0_i  = 16'h0055;
    bus.ready_i = 1'b1;
    tick();
    bus.ld_ni   = 1'b1;
    bus.ready_i = 1'b0;
    check("t4_count", 32'(count_o), 32'd4);
    check("t4_overflow", 32'(overflow_o), 32'd0);
    check("t4_last", 32'(last_o), 32'h0055);
    bus.ready_i = 1'b1;
    check("t4_word1", 32'(bus.data_o), 32'h0012);
    tick();
    check("t4_word2", 32'(bus.data_o), 32'h0013);
    tick();
    check("t4_word3", 32'(bus.data_o), 32'h0014);
    tick();
    check("t4_word4", 32'(bus.data_o), 32'h0055);
    tick();
    bus.ready_i = 1'b0;
    check("t4_empty", 32'(empty_o), 32'd1);

    // 5. continuous push/pop through pointer wrap-around
    bus.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ld_ni  = 1'b0;
      bus.src0_i = 16'h0100 + 16'(i);
      if (i > 0) begin
        check("t5_valid", 32'(bus.valid_o), 32'd1);
        check("t5_order", 32'(bus.data_o), 32'h0100 + 32'(i - 1));
      end
      tick();
      check("t5_count", 32'(count_o), 32'd1);
    end
    bus.ld_ni = 1'b1;
    check("t5_last_word", 32'(bus.data_o), 32'h0109);
    tick();
    bus.ready_i = 1'b0;
    check("t5_empty", 32'(empty_o), 32'd1);

    // 6. reset mid-stream with three words queued and a load pending
    for (int i = 1; i <= 3; i++) begin
      bus.ld_ni  = 1'b0;
      bus.src0_i = 16'h00A0 + 16'(i);
      tick();
    end
    check("t6_count_before", 32'(count_o), 32'd3);
    bus.src0_i = 16'hDEAD;
    reset_i    = 1'b1;
    tick();
    reset_i   = 1'b0;
    bus.ld_ni = 1'b1;
    check("t6_count", 32'(count_o), 32'd0);
    check("t6_valid", 32'(bus.valid_o), 32'd0);
    check("t6_last", 32'(last_o), 32'h0);
    check("t6_data", 32'(bus.data_o), 32'h0);
    bus.ld_ni  = 1'b0;
    bus.src0_i = 16'h1234;
    tick();
    bus.ld_ni = 1'b1;
    check("t6_head_valid", 32'(bus.valid_o), 32'd1);
    check("t6_head_data", 32'(bus.data_o), 32'h1234);
    check("t6_head_count", 32'(count_o), 32'd1);
    check("t6_head_last", 32'(last_o), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/output_port.md
# output_port

Output stage downstream of the sequence control matrix. It consumes the matrix's output-load strobe and output-select and captures the selected datapath word into a small FIFO. It then drains that FIFO to an external consumer (console/LED/UART bridge) over a valid/ready handshake. It reports full so the matrix can stall OUT instructions, and it keeps a sticky overflow flag and a last-written display register.

## Interface

Parameters:
- DATA_WIDTH, 16, width of every data word.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- ADDR_BITS, 2, log2(DEPTH).

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ld_ni  in  1  active-low load strobe, driven by the matrix out_ld_no.
- sel_i  in  1  source select, driven by the matrix out_sel_o: 0 selects src0_i, 1 selects src1_i.
- src0_i  in  DATA_WIDTH  register/ALU result word.
- src1_i  in  DATA_WIDTH  zero-extended IR immediate.
- data_o  out  DATA_WIDTH  head-of-FIFO word; 0 when empty.
- valid_o  out  1  head word is valid.
- ready_i  in  1  consumer accepts the head word.
- full_o  out  1  count == DEPTH; stall request to the matrix.
- empty_o  out  1  count == 0.
- count_o  out  ADDR_BITS+1  number of occupied entries.
- overflow_o  out  1  sticky: a load was dropped.
- last_o  out  DATA_WIDTH  last word accepted into the FIFO.

## Operation

- Push condition: ld_ni == 0 AND (not full OR pop this cycle).
  - The pushed word is sel_i ? src1_i : src0_i, sampled at the edge.
  - The word is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - last_o takes the pushed word.
- Pop condition: valid_o AND ready_i. rd_ptr increments modulo DEPTH.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: count unchanged; both pointers advance.
- Dropped load: ld_ni == 0 while full with no pop.
  - The word is discarded.
  - Pointers, count and last_o are unchanged.
  - overflow_o sets and holds until reset.
- Pop when empty cannot happen, because valid_o is 0. ready_i is ignored when empty.
- Pointers wrap naturally; full and empty are decided by count, never by pointer equality.
- Occupancy states:
  - EMPTY (count = 0): a push goes to PARTIAL, or to FULL if DEPTH reaches 1 entry; DEPTH ≥ 2 makes the latter unreachable.
  - PARTIAL: push only goes to FULL when count reaches DEPTH; pop only goes to EMPTY when count reaches 0; simultaneous push and pop stays.
  - FULL: pop goes to PARTIAL; push with pop stays FULL; push without pop stays FULL and sets overflow_o.

## Timing

- Reset values: data_o = 0, valid_o = 0, full_o = 0, empty_o = 1, count_o = 0, overflow_o = 0, last_o = 0, pointers = 0.
  - Storage contents are not cleared.
  - Reset asserted mid-stream discards all queued words at that edge.
  - Reset has priority over a simultaneous push or pop.
- Push-to-valid latency: with ld_ni low at edge N, valid_o and data_o reflect the word after edge N (first-word fall-through, one cycle).
- data_o is a combinational read of storage at rd_ptr, gated to 0 when empty. valid_o, full_o, empty_o and count_o decode from registered count only.
- full_o rises the cycle after the DEPTH-th push. The matrix must hold ld_ni high while full_o is high; otherwise the overflow rule applies.
- data_o must stay stable while valid_o is 1 and ready_i is 0.

## Structure

- Shared definitions header holds:
  - OUT_SEL_REG = 1'b0 and OUT_SEL_IMM = 1'b1.
  - The DEPTH default.
  - Both are included by the sequence control and this block.
- Sub-module output_fifo_mem: DEPTH × DATA_WIDTH storage with a synchronous write and an asynchronous read port. Pointer, count, flag and select logic stay in output_port.

## Test plan

1. Reset with ld_ni high for 2 cycles: empty_o = 1, valid_o = 0, data_o = 0, count_o = 0, overflow_o = 0.
2. Single push, sel_i = 1, src1_i = 0x00A5, ready_i = 0: the next cycle shows valid_o = 1, data_o = 0x00A5, last_o = 0x00A5, count_o = 1. Holding ready_i = 0 for 3 cycles keeps data_o stable.
3. Fill and overflow: push 0x0001..0x0004 with sel_i = 0, then push 0x0005 with ready_i = 0.
   - full_o = 1 and count_o = 4 stay as they are.
   - overflow_o = 1; last_o = 0x0004.
   - Draining with ready_i = 1 yields 0x0001..0x0004 in order, then empty_o = 1 and overflow_o still 1.
4. Full with simultaneous push/pop: with the FIFO full, set ld_ni = 0, src0_i = 0x0055 and ready_i = 1 for one cycle.
   - Count stays 4; overflow_o stays 0.
   - 0x0055 appears as the 4th word after the 3 older ones.
5. Wrap-around: push and pop continuously for 10 words with ready_i = 1. Output order equals input order and count_o never exceeds 1.
6. Reset mid-stream with 3 words queued and ready_i = 0: the next cycle shows count_o = 0, valid_o = 0, last_o = 0. A following push of 0x1234 appears as the head.
